led_display_ctrl: RTL
=====================

Name: led_display_ctrl

Overview:
- Parametrised LED output stage for the decoder's binary result.
- Registers the decoded value and drives a board LED bank in one of four display modes: static, blink, PWM-dimmed, off.
- Flashes all data LEDs briefly whenever the displayed value changes.
- Handles LED polarity, so the decoder core always works in logical "1 = lit".

Parameters:
DATA_W, 4, width of decoded value shown on LEDs [DATA_W-1:0]
N_LEDS, 6, physical LED count; must satisfy N_LEDS >= DATA_W (elaboration-time check)
CLK_HZ, 27000000, system clock frequency
BLINK_HZ, 2, blink frequency; half period = CLK_HZ/(2*BLINK_HZ) cycles (integer, >= 1)
PWM_W, 8, PWM counter/duty width
FLASH_CYC, 2700000, change-flash duration in clock cycles (>= 1)
ACTIVE_LOW, 1, 1 = physical LED lit by driving 0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_i  in  DATA_W  decoded binary value
data_valid_i  in  1  single-cycle strobe; latch data_i
mode_i  in  2  display mode: 00 STATIC, 01 BLINK, 10 DIM, 11 OFF
duty_i  in  PWM_W  DIM-mode brightness
leds_o  out  N_LEDS  physical LED drive, registered

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: held value = 0, FSM = IDLE, all counters = 0, blink phase = 0 (lit phase), leds_o = all physical-off (all 1s when ACTIVE_LOW = 1, else all 0s).
- Latch: on the data_valid_i edge, held <= data_i. leds_o reflects the new value one cycle later (latency 1 from the latch edge).
- Tick generator: free-running prescaler wraps at half period - 1, then toggles the blink phase. The PWM counter increments every cycle and wraps 2^PWM_W-1 -> 0. Neither counter is reset by mode or data changes.
- Logical data-LED value per mode:
  - STATIC: held.
  - BLINK: held when phase = 0, else 0.
  - DIM: held when pwm_cnt < duty_i, else 0. duty 0 = always off; duty 2^PWM_W-1 = lit 255 of 256 cycles at PWM_W = 8.
  - OFF: 0.
- mode_i and duty_i are sampled every cycle; a change takes effect on the next leds_o update.
- FSM states:
  - IDLE: on data_valid_i with data_i != held, go to FLASH and load flash_cnt = FLASH_CYC-1.
  - FLASH: all DATA_W data LEDs logically lit regardless of mode, except mode OFF, which forces them off. flash_cnt decrements each cycle; at 0 return to IDLE.
  - In FLASH, a data_valid_i with a differing value reloads flash_cnt and stays in FLASH. An equal value or no strobe leaves the count running.
- A data_valid_i with data_i == held updates nothing visible and never starts a flash.
- Spare LEDs [N_LEDS-1:DATA_W] are logically 0 (see Optional Feature).
- Physical output: leds_o = logical XOR {N_LEDS{ACTIVE_LOW}}.
- Reset asserted mid-flash or mid-blink: immediate return to reset values. No glitch beyond the asynchronous clear.

Optional Feature:
- Macro: LED_HEARTBEAT_EN
- Defined and N_LEDS > DATA_W: LED N_LEDS-1 is a heartbeat. It is logically lit when a second counter of blink half-periods is in its even half, i.e. it toggles every 2 blink half-periods, independent of mode (including OFF). Other spare LEDs stay 0.
- Defined with N_LEDS == DATA_W: the feature is inert.
- Undefined: no heartbeat logic; all spare LEDs logically 0.

Decomposition:
- Package led_pkg: mode enum (MODE_STATIC, MODE_BLINK, MODE_DIM, MODE_OFF, 2 bits), FSM state enum (ST_IDLE, ST_FLASH).
- Sub-module led_tick_gen, parameters CLK_HZ and BLINK_HZ: prescaler plus blink-phase toggle. It outputs blink_phase and a single-cycle half_tick used by the heartbeat.

Test Plan:
- Reset: CLK_HZ=16, BLINK_HZ=2, ACTIVE_LOW=1, N_LEDS=6, DATA_W=4; hold rst_n=0 -> leds_o = 6'b111111. Release, STATIC -> leds_o stays 6'b111111.
- Latch and flash: FLASH_CYC=3, STATIC; strobe data 4'b0101 -> 1 cycle later leds_o = 6'b110000 for 3 cycles, then 6'b111010.
- No flash on repeat: strobe 4'b0101 again -> leds_o stays 6'b111010, no flash. Strobe 4'b0110 mid-flash -> flash restarts with a full 3 cycles, then 6'b111001.
- Blink: mode 01, held 4'b1111 -> leds_o alternates 6'b110000 / 6'b111111 every 4 cycles.
- DIM: PWM_W=2; duty 0 -> data LEDs never lit. Duty 3 -> lit 3 of every 4 cycles. Mode OFF -> 6'b111111 even during a flash.
- Heartbeat (LED_HEARTBEAT_EN defined): mode OFF -> leds_o[5] toggles every 8 cycles, leds_o[4:0] = 5'b11111.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED display controller: display modes, FSM states and a
// counter-width helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_DIM    = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink time base: a prescaler that wraps every blink half period, toggling the
// blink phase and emitting a one-cycle half_tick aligned with each toggle.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 27000000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic blink_phase,
  output logic half_tick
);

  localparam int unsigned HALF_CYC = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PRE_W    = cnt_w(HALF_CYC);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_CYC - 1);

  if (HALF_CYC < 1) begin : g_bad_half_period
    $error("led_tick_gen: CLK_HZ/(2*BLINK_HZ) must be at least 1");
  end

  logic [PRE_W-1:0] pre;
  logic             wrap_c;

  assign wrap_c = (pre == PRE_LAST);

  // Free-running prescaler; never restarted by mode or data activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre         <= '0;
      blink_phase <= 1'b0;
      half_tick   <= 1'b0;
    end else begin
      half_tick <= wrap_c;
      if (wrap_c) begin
        pre         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_display_ctrl.sv
// LED output stage: latches the decoded value, flashes on change and drives the
// LED bank in static/blink/dim/off modes. LED_HEARTBEAT_EN adds a heartbeat LED.
module led_display_ctrl
  import led_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned N_LEDS     = 6,
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned FLASH_CYC  = 2700000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  input  logic [1:0]        mode_i,
  input  logic [PWM_W-1:0]  duty_i,
  output logic [N_LEDS-1:0] leds_o
);

  localparam int unsigned FL_W = cnt_w(FLASH_CYC);
  localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLASH_CYC - 1);
  localparam logic [N_LEDS-1:0] POLARITY = {N_LEDS{ACTIVE_LOW}};
  localparam bit HB_ON = (N_LEDS > DATA_W);

  if (N_LEDS < DATA_W) begin : g_bad_led_count
    $error("led_display_ctrl: N_LEDS must be >= DATA_W");
  end
  if (FLASH_CYC < 1) begin : g_bad_flash_cyc
    $error("led_display_ctrl: FLASH_CYC must be >= 1");
  end

  logic [DATA_W-1:0] held;
  state_t            state;
  logic [FL_W-1:0]   flash_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              blink_phase;
  logic              half_tick;
  logic              hb_lit_c;
  logic              change_c;
  mode_t             mode_c;
  logic [DATA_W-1:0] data_c;
  logic [N_LEDS-1:0] logical_c;

  led_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .blink_phase (blink_phase),
    .half_tick   (half_tick)
  );

`ifdef LED_HEARTBEAT_EN
  if (HB_ON) begin : g_hb
    // Counts blink half periods; the top bit gives a two-half-period toggle.
    logic [1:0] hb_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hb_cnt <= '0;
      end else if (half_tick) begin
        hb_cnt <= hb_cnt + 2'd1;
      end
    end
    assign hb_lit_c = ~hb_cnt[1];
  end else begin : g_no_hb
    logic unused_half_tick;
    assign unused_half_tick = half_tick;
    assign hb_lit_c         = 1'b0;
  end
`else
  logic unused_half_tick;
  assign unused_half_tick = half_tick;
  assign hb_lit_c         = 1'b0;
`endif

  assign mode_c   = mode_t'(mode_i);
  assign change_c = data_valid_i && (data_i != held);

  // Logical (1 = lit) LED image from mode, flash state and heartbeat.
  always_comb begin
    data_c    = '0;
    logical_c = '0;
    case (mode_c)
      MODE_STATIC: data_c = held;
      MODE_BLINK:  data_c = blink_phase ? '0 : held;
      MODE_DIM:    data_c = (pwm_cnt < duty_i) ? held : '0;
      MODE_OFF:    data_c = '0;
      default:     data_c = '0;
    endcase
    if ((state == ST_FLASH) && (mode_c != MODE_OFF)) begin
      data_c = '1;
    end
    logical_c = N_LEDS'(data_c);
    if (HB_ON) begin
      logical_c[N_LEDS-1] = hb_lit_c;
    end
  end

  // Held value, change-flash FSM, PWM counter and registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held      <= '0;
      state     <= ST_IDLE;
      flash_cnt <= '0;
      pwm_cnt   <= '0;
      leds_o    <= POLARITY;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      leds_o  <= logical_c ^ POLARITY;
      if (data_valid_i) begin
        held <= data_i;
      end
      case (state)
        ST_IDLE: begin
          if (change_c) begin
            state     <= ST_FLASH;
            flash_cnt <= FL_LOAD;
          end
        end
        ST_FLASH: begin
          if (change_c) begin
            flash_cnt <= FL_LOAD;
          end else if (flash_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            flash_cnt <= flash_cnt - FL_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
